adc_readout_sequencer: RTL and testbench

- Schedules per-ADC readout of the 16 ADC channels on the OFC after each aligned L1A.
- Buffers pending L1As in a bounded counter and walks the ADCs one at a time with a one-hot start_read, skipping masked channels.
- Times out stalled channels so a dead ADC cannot hang the readout.
- Counts transmitted events and records sticky error flags for the slow-control registers.

---
 rtl/adc_readout_sequencer.sv | 175 +++++++++++++++++
 tb/tb_adc_readout_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_readout_sequencer
// Purpose  : Queues aligned L1As and, for each one, walks the enabled ADC
//            channels one at a time with a one-hot start_read request.
//            Channels that never report completion are timed out so the
//            readout always moves on. Keeps an event counter and sticky
//            error flags for slow control.
// Ports    : clk, reset (async, active-high)
//            L1A_Align, need_read     - L1A intake
//            adc_mask                 - channel enables, latched per event
//            one_adc_finish_read      - current channel done
//            err_clr                  - clears error and timeout_cnt
//            start_read, busy, pending, evt_tx, timeout_cnt, error - status
// Revision : 1.0 - initial release
// ============================================================================
module adc_readout_sequencer #(
  parameter int N_ADC   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int EVT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             L1A_Align,
  input  logic             need_read,
  input  logic [N_ADC-1:0] adc_mask,
  input  logic             one_adc_finish_read,
  input  logic             err_clr,
  output logic [N_ADC-1:0] start_read,
  output logic             busy,
  output logic [3:0]       pending,
  output logic [EVT_W-1:0] evt_tx,
  output logic [7:0]       timeout_cnt,
  output logic [2:0]       error
);

  // idx must be able to hold N_ADC itself: that value marks "all scanned".
  localparam int IDX_W = $clog2(N_ADC + 1);
  localparam int SEL_W = $clog2(N_ADC);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [N_ADC-1:0] ONE = {{(N_ADC-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    READ   = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic [N_ADC-1:0]   mask_q, mask_n;
  logic [N_ADC-1:0]   start_n;
  logic [3:0]         pending_n;
  logic [EVT_W-1:0]   evt_n;
  logic [7:0]         tocnt_n;
  logic [2:0]         error_n;
  logic               busy_n;

  logic               evt_done;
  logic               to_hit;
  logic               l1a_ok;
  logic               q_full;
  logic               l1a_inc;
  logic [SEL_W-1:0]   idx_sel;
  logic [2:0]         err_set;
  logic [7:0]         tocnt_base;

  assign idx_sel = idx[SEL_W-1:0];
  assign l1a_ok  = L1A_Align & need_read;
  // A completion in the same cycle does not free a slot for the new L1A.
  assign q_full  = (pending == 4'(DEPTH));
  assign l1a_inc = l1a_ok & ~q_full;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    timer_n    = timer;
    mask_n     = mask_q;
    start_n    = start_read;
    evt_n      = evt_tx;
    evt_done   = 1'b0;
    to_hit     = 1'b0;
    pending_n  = pending;
    err_set    = 3'b000;
    tocnt_base = timeout_cnt;
    tocnt_n    = timeout_cnt;
    error_n    = error;

    unique case (state)
      IDLE: begin
        if (pending != 4'd0) begin
          state_n = SELECT;
          idx_n   = '0;
          mask_n  = adc_mask;
        end
      end
      SELECT: begin
        if (idx == IDX_W'(N_ADC)) begin
          evt_done = 1'b1;
          evt_n    = evt_tx + EVT_W'(1);
          state_n  = IDLE;
        end else if (!mask_q[idx_sel]) begin
          idx_n = idx + IDX_W'(1);
        end else begin
          start_n = ONE << idx_sel;
          timer_n = '0;
          state_n = READ;
        end
      end
      READ: begin
        // A done arriving on the last allowed cycle wins over the timeout.
        if (one_adc_finish_read || timer == TMR_W'(TIMEOUT - 1)) begin
          to_hit  = ~one_adc_finish_read;
          start_n = '0;
          idx_n   = idx + IDX_W'(1);
          state_n = SELECT;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      default: begin
        start_n = '0;
        state_n = IDLE;
      end
    endcase

    unique case ({l1a_inc, evt_done})
      2'b10:   pending_n = pending + 4'd1;
      2'b01:   pending_n = pending - 4'd1;
      default: pending_n = pending;
    endcase

    // New error events are OR-ed in after the clear so they are never lost.
    err_set[0] = L1A_Align & ~need_read;
    err_set[1] = l1a_ok & q_full;
    err_set[2] = to_hit;
    error_n    = (err_clr ? 3'b000 : error) | err_set;

    if (err_clr) tocnt_base = 8'd0;
    tocnt_n = tocnt_base;
    if (to_hit && tocnt_base != 8'hFF) tocnt_n = tocnt_base + 8'd1;

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      mask_q      <= '0;
      start_read  <= '0;
      busy        <= 1'b0;
      pending     <= 4'd0;
      evt_tx      <= '0;
      timeout_cnt <= 8'd0;
      error       <= 3'b000;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      timer       <= timer_n;
      mask_q      <= mask_n;
      start_read  <= start_n;
      busy        <= busy_n;
      pending     <= pending_n;
      evt_tx      <= evt_n;
      timeout_cnt <= tocnt_n;
      error       <= error_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_readout_sequencer
// Purpose  : Directed self-checking bench for adc_readout_sequencer. A
//            behavioural ADC responder answers start_read after a programmable
//            delay (optionally never, for one channel); a monitor records the
//            sequence of start_read requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_readout_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        L1A_Align = 1'b0;
  logic        need_read = 1'b0;
  logic [15:0] adc_mask = 16'hFFFF;
  logic        one_adc_finish_read = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] start_read;
  logic        busy;
  logic [3:0]  pending;
  logic [15:0] evt_tx;
  logic [7:0]  timeout_cnt;
  logic [2:0]  error;

  int n_checks = 0;
  int n_fail   = 0;

  // responder controls
  logic        resp_en = 1'b1;
  int          resp_delay = 5;
  logic [15:0] dead_mask = 16'h0000;
  int          resp_cnt = 0;

  // monitor state
  logic [15:0] seq[$];
  logic [15:0] last_sr = 16'h0000;
  int          pend_max = 0;
  int          sr_bad = 0;

  adc_readout_sequencer #(
    .N_ADC(16), .DEPTH(4), .TIMEOUT(1024), .EVT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .L1A_Align(L1A_Align),
    .need_read(need_read),
    .adc_mask(adc_mask),
    .one_adc_finish_read(one_adc_finish_read),
    .err_clr(err_clr),
    .start_read(start_read),
    .busy(busy),
    .pending(pending),
    .evt_tx(evt_tx),
    .timeout_cnt(timeout_cnt),
    .error(error)
  );

  always #5 clk = ~clk;

  // ADC model: done pulses resp_delay negedges after a request appears.
  always @(negedge clk) begin
    if (resp_en && start_read != 16'h0000 && start_read != dead_mask) begin
      if (resp_cnt == resp_delay) begin
        one_adc_finish_read = 1'b1;
      end else begin
        one_adc_finish_read = 1'b0;
        resp_cnt = resp_cnt + 1;
      end
    end else begin
      one_adc_finish_read = 1'b0;
      resp_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (start_read != 16'h0000 && last_sr == 16'h0000) seq.push_back(start_read);
    last_sr = start_read;
    if (int'(pending) > pend_max) pend_max = int'(pending);
    if (!$onehot0(start_read) || (start_read != 16'h0000 && !busy)) sr_bad = sr_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seq.delete();
    pend_max = 0;
    @(negedge clk);
  endtask

  task automatic l1a(input logic nr);
    @(negedge clk);
    L1A_Align = 1'b1;
    need_read = nr;
    @(negedge clk);
    L1A_Align = 1'b0;
    need_read = 1'b0;
  endtask

  task automatic wait_evt(input logic [15:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (evt_tx == target && !busy) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int hold;
    do_reset();

    // reset state
    check("rst_start_read", 32'(start_read), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_evt_tx", 32'(evt_tx), 32'h0);
    check("rst_status", {timeout_cnt, 5'd0, error}, 32'h0);

    // single event, all channels, done 5 cycles after each request
    adc_mask = 16'hFFFF;
    l1a(1'b1);
    check("t1_pending_after_l1a", 32'(pending), 32'h1);
    @(negedge clk);
    check("t1_busy_select", 32'(busy), 32'h1);
    @(negedge clk);
    check("t1_first_start", 32'(start_read), 32'h0001);
    wait_evt(16'd1, 500);
    check("t1_evt_tx", 32'(evt_tx), 32'h1);
    check("t1_pending_end", 32'(pending), 32'h0);
    check("t1_error", 32'(error), 32'h0);
    check("t1_seq_len", 32'(seq.size()), 32'd16);
    hold = 0;
    foreach (seq[i]) if (seq[i] != (16'h0001 << i)) hold = hold + 1;
    check("t1_seq_onehot_walk", 32'(hold), 32'h0);

    // sparse mask, two back-to-back L1As
    do_reset();
    adc_mask = 16'h0005;
    @(negedge clk);
    L1A_Align = 1'b1; need_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    L1A_Align = 1'b0; need_read = 1'b0;
    wait_evt(16'd2, 300);
    check("t2_evt_tx", 32'(evt_tx), 32'h2);
    check("t2_pend_max", 32'(pend_max), 32'h2);
    check("t2_seq_len", 32'(seq.size()), 32'd4);
    if (seq.size() == 4)
      check("t2_seq", {seq[0], seq[1]} ^ {seq[2], seq[3]} ^ {seq[0], seq[1]}, {16'h0001, 16'h0004});
    check("t2_seq_first", 32'(seq.size() > 0 ? seq[0] : 16'h0), 32'h0001);

    // queue overflow: five L1As with the ADC silent
    do_reset();
    adc_mask = 16'hFFFF;
    resp_en = 1'b0;
    @(negedge clk);
    L1A_Align = 1'b1; need_read = 1'b1;
    repeat (5) @(negedge clk);
    L1A_Align = 1'b0; need_read = 1'b0;
    check("t3_pending_full", 32'(pending), 32'h4);
    check("t3_error_drop", 32'(error), 32'h2);
    resp_en = 1'b1;
    resp_delay = 0;
    wait_evt(16'd4, 1500);
    check("t3_evt_tx", 32'(evt_tx), 32'h4);
    check("t3_pending_end", 32'(pending), 32'h0);

    // ADC3 dead: timeout after exactly TIMEOUT cycles
    do_reset();
    resp_delay = 5;
    dead_mask = 16'h0008;
    l1a(1'b1);
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (start_read == 16'h0008) hold = hold + 1;
      if (evt_tx == 16'd1 && !busy) break;
      @(negedge clk);
    end
    check("t4_hold_cycles", 32'(hold), 32'd1024);
    check("t4_next_after_dead", 32'(seq.size() > 4 ? seq[4] : 16'h0), 32'h0010);
    check("t4_timeout_cnt", 32'(timeout_cnt), 32'h1);
    check("t4_error", 32'(error), 32'h4);
    check("t4_evt_tx", 32'(evt_tx), 32'h1);
    dead_mask = 16'h0000;

    // L1A without need_read, then err_clr
    do_reset();
    l1a(1'b0);
    check("t5_error0", 32'(error), 32'h1);
    check("t5_pending", 32'(pending), 32'h0);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t5_error_clr", 32'(error), 32'h0);

    // async reset in the middle of an event
    do_reset();
    l1a(1'b1);
    hold = 0;
    for (int i = 0; i < 200; i++) begin
      if (start_read == 16'h0040) begin hold = 1; break; end
      @(negedge clk);
    end
    check("t6_reached_adc6", 32'(hold), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("t6_async_start_read", 32'(start_read), 32'h0);
    check("t6_async_status", {busy, pending, evt_tx, timeout_cnt, error}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    seq.delete();
    l1a(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t6_restart_adc0", 32'(start_read), 32'h0001);
    wait_evt(16'd1, 500);
    check("t6_evt_tx", 32'(evt_tx), 32'h1);

    check("start_read_onehot_in_read", 32'(sr_bad), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
